// File: rtl/aes_round_sched.sv
// Sequencer and round-robin arbiter for a single iterative AES round datapath.
// Owns the 128-bit cipher state and steps round keys 0..Nr for one block at a time.
module aes_round_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic              eph1,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*128-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              key_ready,
  input  logic [1:0]        key_size,
  output logic [3:0]        key_idx,
  input  logic [127:0]      round_key,
  output logic [127:0]      dp_in,
  output logic              dp_last,
  input  logic [127:0]      dp_out,
  output logic              busy,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [IDW-1:0]    out_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [127:0]        st_q, st_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [3:0]          nr_q, nr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      rr_q, rr_d;

  logic [(1<<IDW)-1:0] vld_ext;
  logic                gnt_found;
  logic [IDW-1:0]      gnt_idx;
  logic [127:0]        gnt_data;
  logic                grant;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    case (ks)
      2'b01:   return 4'd12;
      2'b10:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Round-robin scan starting at rr_q, wrapping modulo NREQ
  always_comb begin
    vld_ext = '0;
    vld_ext[NREQ-1:0] = req_valid;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_found && vld_ext[wrap_idx(rr_q, i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_q, i);
      end
    end
    gnt_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_idx == IDW'(j)) gnt_data = req_data[j*128 +: 128];
    end
  end

  // Gated by reset_n so every output reads zero while reset is held
  assign grant = reset_n && (state_q == IDLE) && key_ready &&
                 (key_size != 2'b11) && gnt_found;

  assign dp_in = st_q;

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = RUN;
      RUN:     if (rnd_q == nr_q) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    key_idx   = 4'd0;
    dp_last   = 1'b0;
    busy      = 1'b0;
    cfg_err   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    case (state_q)
      IDLE: begin
        for (int j = 0; j < NREQ; j++) req_ready[j] = grant && (gnt_idx == IDW'(j));
        cfg_err = reset_n && (key_size == 2'b11) && (|req_valid);
      end
      RUN: begin
        key_idx = rnd_q;
        dp_last = (rnd_q == nr_q);
        busy    = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = st_q;
        out_id    = id_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d  = st_q;
    rnd_d = rnd_q;
    nr_d  = nr_q;
    id_d  = id_q;
    rr_d  = rr_q;
    if (grant) begin
      st_d  = gnt_data ^ round_key;
      nr_d  = nr_of(key_size);
      id_d  = gnt_idx;
      rr_d  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      rnd_d = 4'd1;
    end else if (state_q == RUN) begin
      st_d = dp_out;
      if (rnd_q != nr_q) rnd_d = rnd_q + 4'd1;
    end
  end

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= '0;
      rnd_q <= 4'd0;
      nr_q  <= 4'd10;
      id_q  <= '0;
      rr_q  <= '0;
    end else begin
      st_q  <= st_d;
      rnd_q <= rnd_d;
      nr_q  <= nr_d;
      id_q  <= id_d;
      rr_q  <= rr_d;
    end
  end

endmodule
